// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, depth helper and pointer type for the sync FIFO slice
package fifo_pkg;
  localparam int ADDR_SIZE_DEF = 4;
  localparam int DATA_SIZE_DEF = 8;
  typedef logic [ADDR_SIZE_DEF:0] ptr_t;
  function automatic int depth_f(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/fifo_ram_2p.sv
// fifo_ram_2p: two-port FIFO storage; read port is combinational under SYNC_FIFO_FWFT_EN, registered otherwise
module fifo_ram_2p #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [1<<AW];
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
`ifdef SYNC_FIFO_FWFT_EN
  logic unused_rd;
  assign unused_rd = rst_n ^ re;
  assign rdata = mem_q[raddr];
`else
  logic [DW-1:0] rdata_q, rdata_d;
  always_comb rdata_d = re ? mem_q[raddr] : rdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else rdata_q <= rdata_d;
  end
  assign rdata = rdata_q;
`endif
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with count, thresholds and sticky errors; SYNC_FIFO_FWFT_EN selects fall-through reads
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_en,
  input  logic [DATA_SIZE-1:0] w_data,
  input  logic                 r_en,
  output logic [DATA_SIZE-1:0] r_data,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 err_clr
);
  localparam int DEPTH = depth_f(ADDR_SIZE);
  localparam int PW = ADDR_SIZE + 1;
  localparam logic [ADDR_SIZE:0] AF_LVL = PW'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_SIZE:0] AE_LVL = PW'(AE_MARGIN);
  localparam logic [ADDR_SIZE:0] ONE = {{ADDR_SIZE{1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE:0] MSB = {1'b1, {ADDR_SIZE{1'b0}}};

  if (AF_MARGIN >= DEPTH || AE_MARGIN >= DEPTH) begin : g_bad_margin
    $error("sync_fifo_ctrl: AF_MARGIN and AE_MARGIN must be below DEPTH");
  end

  logic [ADDR_SIZE:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
  logic ovf_q, ovf_d, unf_q, unf_d, w_acc, r_acc;

  always_comb begin
    w_acc   = w_en && !full_q;
    r_acc   = r_en && !empty_q;
    wptr_d  = w_acc ? wptr_q + ONE : wptr_q;
    rptr_d  = r_acc ? rptr_q + ONE : rptr_q;
    count_d = wptr_d - rptr_d;
    full_d  = (wptr_d ^ rptr_d) == MSB;
    empty_d = wptr_d == rptr_d;
    af_d    = count_d >= AF_LVL;
    ae_d    = count_d <= AE_LVL;
    ovf_d   = (w_en && full_q) || (ovf_q && !err_clr);
    unf_d   = (r_en && empty_q) || (unf_q && !err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  fifo_ram_2p #(.AW(ADDR_SIZE), .DW(DATA_SIZE)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_acc),
    .waddr (wptr_q[ADDR_SIZE-1:0]),
    .wdata (w_data),
    .re    (r_acc),
    .raddr (rptr_q[ADDR_SIZE-1:0]),
    .rdata (r_data)
  );

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: table-driven directed checks for sync_fifo_ctrl at DEPTH=16
module tb_sync_fifo_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, w_en = 1'b0, r_en = 1'b0, err_clr = 1'b0;
  logic [7:0] w_data = '0, r_data;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int total = 0, bad = 0;

  typedef struct {
    logic w, r, c;
    logic [7:0] d;
    int cnt;
    logic ovf, unf, chk;
    logic [7:0] rd;
  } vec_t;
  vec_t tv[$];

  sync_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .r_data(r_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic void add(logic w, logic r, logic c, logic [7:0] d, int cnt,
                              logic ovf, logic unf, logic chk, logic [7:0] rd);
    vec_t v;
    v.w = w; v.r = r; v.c = c; v.d = d; v.cnt = cnt;
    v.ovf = ovf; v.unf = unf; v.chk = chk; v.rd = rd;
    tv.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] status_exp(int cnt, logic ovf, logic unf);
    return {5'(cnt), cnt == 16, cnt == 0, cnt >= 14, cnt <= 2, ovf, unf};
  endfunction

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    w_en = w; r_en = r; err_clr = c; w_data = d;
    @(posedge clk);
    #1;
    w_en = 0; r_en = 0; err_clr = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) add(1, 0, 0, 8'(i), i + 1, 0, 0, 0, 0);
    add(1, 0, 0, 8'hAA, 16, 1, 0, 0, 0);
    add(0, 0, 1, 0, 16, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 15 - i, 0, 0, 1, 8'(i));
    add(0, 1, 0, 0, 0, 0, 1, 1, 8'h0F);
    add(0, 0, 1, 0, 0, 0, 0, 1, 8'h0F);
    for (int i = 0; i < 10; i++) add(1, 0, 0, 8'(8'h10 + i), i + 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 9 - i, 0, 0, 1, 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) add(1, 0, 0, 8'(8'h20 + i), i + 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) add(1, 1, 0, 8'(8'h24 + i), 4, 0, 0, 1, 8'(8'h20 + i));
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 3 - i, 0, 0, 1, 8'(8'h34 + i));
    for (int i = 0; i < 16; i++) add(1, 0, 0, 8'(8'h40 + i), i + 1, 0, 0, 0, 0);
    add(1, 1, 0, 8'hEE, 15, 1, 0, 1, 8'h40);
    add(1, 0, 0, 8'h50, 16, 1, 0, 0, 0);
    add(1, 0, 1, 8'hEF, 16, 1, 0, 0, 0);
    add(0, 0, 1, 0, 16, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) add(0, 1, 0, 0, 15 - i, 0, 0, 1, 8'(8'h41 + i));
    add(0, 1, 0, 0, 0, 0, 0, 1, 8'h50);
    add(1, 1, 0, 8'h60, 1, 0, 1, 1, 8'h50);
    add(0, 1, 0, 0, 0, 0, 1, 1, 8'h60);
    add(0, 1, 1, 0, 0, 0, 1, 1, 8'h60);
    add(0, 0, 1, 0, 0, 0, 0, 1, 8'h60);

    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_status", 32'({count, full, empty, almost_full, almost_empty, overflow, underflow}),
          32'(status_exp(0, 0, 0)));
`ifndef SYNC_FIFO_FWFT_EN
    check("reset_rdata", 32'(r_data), 32'h00);
`endif

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].w, tv[i].r, tv[i].c, tv[i].d);
      check($sformatf("vec%0d_status", i),
            32'({count, full, empty, almost_full, almost_empty, overflow, underflow}),
            32'(status_exp(tv[i].cnt, tv[i].ovf, tv[i].unf)));
`ifndef SYNC_FIFO_FWFT_EN
      if (tv[i].chk) check($sformatf("vec%0d_rdata", i), 32'(r_data), 32'(tv[i].rd));
`endif
    end

    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h70 + i));
    check("pre_reset_count", 32'(count), 32'd5);
    w_en = 1; w_data = 8'h99;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_count", 32'(count), 32'd0);
    check("async_reset_empty", 32'(empty), 32'd1);
    @(posedge clk);
    #1;
    w_en = 0;
    check("in_reset_count", 32'(count), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_empty", 32'({count, empty}), 32'({5'd0, 1'b1}));
    step(1, 0, 0, 8'h55);
    check("post_reset_write", 32'({count, empty}), 32'({5'd1, 1'b0}));
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft_head", 32'(r_data), 32'h55);
`endif
    step(0, 1, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("post_reset_read", 32'(r_data), 32'h55);
`endif
    check("post_reset_drain", 32'({count, empty, underflow}), 32'({5'd0, 1'b1, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
